// File: rtl/dmem_lsu_pkg.sv
// Shared types and encodings for the data-memory load/store unit.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RWAIT  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] MODE_NONE = 3'b000;
  localparam logic [2:0] MODE_BYTE = 3'b011;
  localparam logic [2:0] MODE_HALF = 3'b100;
  localparam logic [2:0] MODE_WORD = 3'b010;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] access_size(input logic [2:0] f3);
    logic [2:0] sz;
    case (f3[1:0])
      2'b00:   sz = 3'd1;
      2'b01:   sz = 3'd2;
      default: sz = 3'd4;
    endcase
    return sz;
  endfunction

  // Only the sub-word modes that leave neighbouring bytes intact are ever produced.
  function automatic logic [2:0] store_mode(input logic [2:0] f3);
    logic [2:0] m;
    case (f3[1:0])
      2'b00:   m = MODE_BYTE;
      2'b01:   m = MODE_HALF;
      default: m = MODE_WORD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lsu_load_extend.sv
// Sign/zero extension of a raw memory word per RV32I load funct3; addressed byte sits in [7:0].
module lsu_load_extend
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  // Select and extend the addressed lane.
  always_comb begin
    result = 32'd0;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   result = {24'd0, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   result = {16'd0, raw[15:0]};
      F3_W:    result = raw;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: validates one request at a time, drives the data memory, returns an extended response.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_rd_we,
  output logic [1:0]        resp_err,
  output logic              mem_we,
  output logic [2:0]        mem_wmode,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e  state_r, state_nxt_s;
  logic        store_r, store_nxt_s;
  logic [2:0]  funct3_r, funct3_nxt_s;
  logic [4:0]  rd_r, rd_nxt_s;
  logic [1:0]  req_err_s;
  logic [ADDR_W:0] req_end_s;
  logic [31:0] ext_s;

  logic        resp_valid_nxt_s, resp_rd_we_nxt_s, mem_we_nxt_s;
  logic [31:0] resp_rdata_nxt_s, mem_addr_nxt_s, mem_wdata_nxt_s;
  logic [4:0]  resp_rd_nxt_s;
  logic [1:0]  resp_err_nxt_s;
  logic [2:0]  mem_wmode_nxt_s;

  lsu_load_extend u_ext (
    .funct3 (funct3_r),
    .raw    (mem_rdata),
    .result (ext_s)
  );

  assign req_ready = (state_r == ST_IDLE);
  assign req_end_s = {1'b0, req_addr} + (ADDR_W+1)'(access_size(req_funct3));

  // Request classification; the if-chain encodes illegal > misaligned > range.
  always_comb begin
    req_err_s = ERR_OK;
    if (!f3_legal(req_store, req_funct3)) begin
      req_err_s = ERR_ILLEGAL;
    end else if ((req_funct3[1:0] == 2'b01 && req_addr[0] != 1'b0) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
      req_err_s = ERR_MISALIGN;
    end else if (req_end_s > (ADDR_W+1)'(MEM_BYTES)) begin
      req_err_s = ERR_RANGE;
    end else begin
      req_err_s = ERR_OK;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt_s      = state_r;
    store_nxt_s      = store_r;
    funct3_nxt_s     = funct3_r;
    rd_nxt_s         = rd_r;
    resp_valid_nxt_s = resp_valid;
    resp_rdata_nxt_s = resp_rdata;
    resp_rd_nxt_s    = resp_rd;
    resp_rd_we_nxt_s = resp_rd_we;
    resp_err_nxt_s   = resp_err;
    mem_we_nxt_s     = 1'b0;
    mem_wmode_nxt_s  = mem_wmode;
    mem_addr_nxt_s   = mem_addr;
    mem_wdata_nxt_s  = mem_wdata;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          store_nxt_s  = req_store;
          funct3_nxt_s = req_funct3;
          rd_nxt_s     = req_rd;
          if (req_err_s != ERR_OK) begin
            state_nxt_s      = ST_RESP;
            resp_valid_nxt_s = 1'b1;
            resp_rdata_nxt_s = 32'd0;
            resp_rd_nxt_s    = req_rd;
            resp_rd_we_nxt_s = 1'b0;
            resp_err_nxt_s   = req_err_s;
          end else begin
            state_nxt_s     = ST_ACCESS;
            mem_we_nxt_s    = req_store;
            mem_wmode_nxt_s = req_store ? store_mode(req_funct3) : MODE_NONE;
            mem_addr_nxt_s  = 32'(req_addr);
            mem_wdata_nxt_s = req_store ? req_wdata : 32'd0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (store_r) begin
          state_nxt_s      = ST_RESP;
          resp_valid_nxt_s = 1'b1;
          resp_rdata_nxt_s = 32'd0;
          resp_rd_nxt_s    = rd_r;
          resp_rd_we_nxt_s = 1'b0;
          resp_err_nxt_s   = ERR_OK;
        end else begin
          state_nxt_s = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        state_nxt_s      = ST_RESP;
        resp_valid_nxt_s = 1'b1;
        resp_rdata_nxt_s = ext_s;
        resp_rd_nxt_s    = rd_r;
        resp_rd_we_nxt_s = (rd_r != 5'd0);
        resp_err_nxt_s   = ERR_OK;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s      = ST_IDLE;
          resp_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s      = ST_IDLE;
        resp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and request-context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      store_r  <= 1'b0;
      funct3_r <= 3'd0;
      rd_r     <= 5'd0;
    end else begin
      state_r  <= state_nxt_s;
      store_r  <= store_nxt_s;
      funct3_r <= funct3_nxt_s;
      rd_r     <= rd_nxt_s;
    end
  end

  // Registered response and memory-interface outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_rd    <= 5'd0;
      resp_rd_we <= 1'b0;
      resp_err   <= ERR_OK;
      mem_we     <= 1'b0;
      mem_wmode  <= MODE_NONE;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      resp_valid <= resp_valid_nxt_s;
      resp_rdata <= resp_rdata_nxt_s;
      resp_rd    <= resp_rd_nxt_s;
      resp_rd_we <= resp_rd_we_nxt_s;
      resp_err   <= resp_err_nxt_s;
      mem_we     <= mem_we_nxt_s;
      mem_wmode  <= mem_wmode_nxt_s;
      mem_addr   <= mem_addr_nxt_s;
      mem_wdata  <= mem_wdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a byte-addressed behavioural data memory.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_rd_we, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic [2:0]  mem_wmode;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  logic [2:0] last_mode = 3'd0;
  logic [7:0] mem [0:1023];

  dmem_lsu #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_rd_we(resp_rd_we), .resp_err(resp_err),
    .mem_we(mem_we), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: unknown write modes write the full word so a wrong mode corrupts neighbours.
  always @(posedge clk) begin
    logic [9:0] a;
    a = mem_addr[9:0];
    if (mem_we) begin
      we_cnt    <= we_cnt + 1;
      last_mode <= mem_wmode;
      case (mem_wmode)
        3'b011: mem[a] <= mem_wdata[7:0];
        3'b100: begin
          mem[a]         <= mem_wdata[7:0];
          mem[a + 10'd1] <= mem_wdata[15:8];
        end
        default: begin
          mem[a]         <= mem_wdata[7:0];
          mem[a + 10'd1] <= mem_wdata[15:8];
          mem[a + 10'd2] <= mem_wdata[23:16];
          mem[a + 10'd3] <= mem_wdata[31:24];
        end
      endcase
    end else begin
      mem_rdata <= {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: accept, measure latency (accept edge counts as 1), optionally hold, then consume.
  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                     input int exp_lat, input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                     input logic exp_rd_we, input int exp_we, input logic [2:0] exp_mode,
                     input int hold);
    int lat;
    int we0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    check({tag, ".rd_we"}, 32'(resp_rd_we), 32'(exp_rd_we));
    check({tag, ".rd"}, 32'(resp_rd), 32'(rd));
    check({tag, ".we_cycles"}, 32'(we_cnt - we0), 32'(exp_we));
    if (exp_we != 0) check({tag, ".wmode"}, 32'(last_mode), 32'(exp_mode));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hold_rdata"}, resp_rdata, exp_rdata);
      check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #3;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_wmode", 32'(mem_wmode), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst = 1'b1;

    // tag, st, f3, addr, wdata, rd, lat, rdata, err, rd_we, we, mode, hold
    txn("sw10",   1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 5'd1, 2, 32'h0,        2'b00, 1'b0, 1, 3'b010, 0);
    txn("lw10",   1'b0, 3'b010, 32'h10,  32'h0,        5'd5, 3, 32'hDEADBEEF, 2'b00, 1'b1, 0, 3'b000, 0);
    txn("sw20",   1'b1, 3'b010, 32'h20,  32'h11223344, 5'd2, 2, 32'h0,        2'b00, 1'b0, 1, 3'b010, 0);
    txn("sb20",   1'b1, 3'b000, 32'h20,  32'h000000F5, 5'd2, 2, 32'h0,        2'b00, 1'b0, 1, 3'b011, 0);
    txn("lw20",   1'b0, 3'b010, 32'h20,  32'h0,        5'd6, 3, 32'h112233F5, 2'b00, 1'b1, 0, 3'b000, 0);
    txn("lb20",   1'b0, 3'b000, 32'h20,  32'h0,        5'd7, 3, 32'hFFFFFFF5, 2'b00, 1'b1, 0, 3'b000, 0);
    txn("lbu20",  1'b0, 3'b100, 32'h20,  32'h0,        5'd8, 3, 32'h000000F5, 2'b00, 1'b1, 0, 3'b000, 0);
    txn("sw30",   1'b1, 3'b010, 32'h30,  32'h7777AAAA, 5'd0, 2, 32'h0,        2'b00, 1'b0, 1, 3'b010, 0);
    txn("sh30",   1'b1, 3'b001, 32'h30,  32'h12348001, 5'd0, 2, 32'h0,        2'b00, 1'b0, 1, 3'b100, 0);
    txn("lw30",   1'b0, 3'b010, 32'h30,  32'h0,        5'd9, 3, 32'h77778001, 2'b00, 1'b1, 0, 3'b000, 0);
    txn("lh30",   1'b0, 3'b001, 32'h30,  32'h0,        5'd9, 3, 32'hFFFF8001, 2'b00, 1'b1, 0, 3'b000, 0);
    txn("lhu30",  1'b0, 3'b101, 32'h30,  32'h0,        5'd9, 3, 32'h00008001, 2'b00, 1'b1, 0, 3'b000, 0);
    txn("lw_rd0", 1'b0, 3'b010, 32'h10,  32'h0,        5'd0, 3, 32'hDEADBEEF, 2'b00, 1'b0, 0, 3'b000, 0);
    txn("lw13",   1'b0, 3'b010, 32'h13,  32'h0,        5'd3, 1, 32'h0,        2'b01, 1'b0, 0, 3'b000, 0);
    txn("sw13",   1'b1, 3'b010, 32'h13,  32'hFFFFFFFF, 5'd3, 1, 32'h0,        2'b01, 1'b0, 0, 3'b000, 0);
    txn("lw3fe",  1'b0, 3'b010, 32'h3FE, 32'h0,        5'd3, 1, 32'h0,        2'b01, 1'b0, 0, 3'b000, 0);
    txn("lh3ff",  1'b0, 3'b001, 32'h3FF, 32'h0,        5'd3, 1, 32'h0,        2'b01, 1'b0, 0, 3'b000, 0);
    txn("lw400",  1'b0, 3'b010, 32'h400, 32'h0,        5'd3, 1, 32'h0,        2'b10, 1'b0, 0, 3'b000, 0);
    txn("lh3fe",  1'b0, 3'b001, 32'h3FE, 32'h0,        5'd3, 3, 32'h0,        2'b00, 1'b1, 0, 3'b000, 0);
    txn("lw3fc",  1'b0, 3'b010, 32'h3FC, 32'h0,        5'd3, 3, 32'h0,        2'b00, 1'b1, 0, 3'b000, 0);
    txn("lf3_011",1'b0, 3'b011, 32'h10,  32'h0,        5'd4, 1, 32'h0,        2'b11, 1'b0, 0, 3'b000, 0);
    txn("lf3_011m",1'b0,3'b011, 32'h13,  32'h0,        5'd4, 1, 32'h0,        2'b11, 1'b0, 0, 3'b000, 0);
    txn("sf3_100",1'b1, 3'b100, 32'h10,  32'h0,        5'd4, 1, 32'h0,        2'b11, 1'b0, 0, 3'b000, 0);
    txn("lw10h",  1'b0, 3'b010, 32'h10,  32'h0,        5'd5, 3, 32'hDEADBEEF, 2'b00, 1'b1, 0, 3'b000, 5);

    // Reset asserted during a store's ACCESS cycle.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40;
    req_wdata = 32'hCAFEF00D; req_rd = 5'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid.mem_we_access", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check("mid.mem_we_drop", 32'(mem_we), 32'd0);
    check("mid.req_ready", 32'(req_ready), 32'd1);
    check("mid.mem_addr", mem_addr, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("post.resp_valid", 32'(resp_valid), 32'd0);
    check("post.req_ready", 32'(req_ready), 32'd1);
    check("post.mem_we", 32'(mem_we), 32'd0);
    check("post.mem_wmode", 32'(mem_wmode), 32'd0);
    check("post.mem_wdata", mem_wdata, 32'd0);
    check("post.resp_err", 32'(resp_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
